// File: rtl/nand_page_target_if.sv
// nand_page_target_if: control/handshake signals of one NFC flash channel.
// The tristate data bus F_IO is kept as a plain inout on the target so the
// bus resolution happens at a module port.
//   F_CLE   command latch enable          (master -> slave)
//   F_ALE   address latch enable          (master -> slave)
//   F_WEN   write enable, active low      (master -> slave)
//   F_REN   read enable, active low       (master -> slave)
//   F_RB    1 = ready, 0 = busy           (slave -> master)
//   cmd_err one-cycle protocol error flag (slave -> master)
interface nand_page_target_if;
  logic F_CLE;
  logic F_ALE;
  logic F_WEN;
  logic F_REN;
  logic F_RB;
  logic cmd_err;

  modport master (output F_CLE, F_ALE, F_WEN, F_REN, input F_RB, cmd_err);
  modport slave  (input F_CLE, F_ALE, F_WEN, F_REN, output F_RB, cmd_err);
endinterface

// File: rtl/nand_page_target.sv
// nand_page_target: NAND flash target model for one NFC channel. Holds
// NUM_PAGES x PAGE_BYTES of page memory, decodes reset (FF), read (00 + addr)
// and program (80 + addr + data + 10) sequences, and drives R/B# busy windows.
// Ports:
//   clk   clock, all logic on posedge
//   rst   asynchronous active-low reset (memory contents are not cleared)
//   F_IO  8-bit tristate data bus, driven only by the output enable
//   bus   slave modport: F_CLE/F_ALE/F_WEN/F_REN in, F_RB/cmd_err out
// Config macro: NAND_STATUS_EN adds read-status command 70 and STATUS state.
//
// state    | meaning
// IDLE     | waiting for a command byte
// ADDR     | collecting ADDR_CYCLES address bytes for a read or program
// BUSY     | R/B# low, busy counter running, then go to after_busy
// READ_OUT | page byte at col driven on F_IO, REN rising edge advances col
// PROG_IN  | data bytes buffered, 10 commits them, FF discards them
// STATUS   | status byte driven on F_IO until the next command (optional)
module nand_page_target #(
  parameter int PAGE_BYTES  = 32,
  parameter int NUM_PAGES   = 4,
  parameter int ADDR_CYCLES = 3,
  parameter int T_RST       = 4,
  parameter int T_R         = 8,
  parameter int T_PROG      = 16
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [7:0]       F_IO,
  nand_page_target_if.slave bus
);
  localparam int CW    = $clog2(PAGE_BYTES);
  localparam int PW    = $clog2(NUM_PAGES);
  localparam int AW    = $clog2(ADDR_CYCLES + 1);
  localparam int T_MAX = (T_PROG > T_R) ? ((T_PROG > T_RST) ? T_PROG : T_RST)
                                        : ((T_R > T_RST) ? T_R : T_RST);
  localparam int BW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BUSY, S_READ_OUT, S_PROG_IN
`ifdef NAND_STATUS_EN
    , S_STATUS
`endif
  } state_t;

  state_t                state, after_busy;
  logic                  op_prog;
  logic [CW-1:0]         col;
  logic [PW-1:0]         page;
  logic [AW-1:0]         addr_cnt;
  logic [BW-1:0]         busy_cnt;
  logic                  rb, err, oe_q, wen_q, ren_q;
  logic [PAGE_BYTES-1:0] mask;
  logic [PAGE_BYTES*8-1:0] rd_flat;
  logic [7:0]            io_in, dout;
  logic                  wr_stb, rd_stb, cyc_cmd, cyc_addr, cyc_data, cyc_bad;
  logic                  cmd_rst, commit, drive;

  assign io_in    = F_IO;
  assign wr_stb   = !wen_q && bus.F_WEN;
  assign rd_stb   = !ren_q && bus.F_REN;
  assign cyc_cmd  = wr_stb &&  bus.F_CLE && !bus.F_ALE;
  assign cyc_addr = wr_stb && !bus.F_CLE &&  bus.F_ALE;
  assign cyc_data = wr_stb && !bus.F_CLE && !bus.F_ALE;
  assign cyc_bad  = wr_stb &&  bus.F_CLE &&  bus.F_ALE;
  assign cmd_rst  = cyc_cmd && (io_in == 8'hFF);
  // Any non-FF command leaving PROG_IN keeps the buffered bytes (10 or error).
  assign commit   = cyc_cmd && (state == S_PROG_IN) && (io_in != 8'hFF);

`ifdef NAND_STATUS_EN
  logic status_pend, cmd_status, show_status;
  assign cmd_status  = cyc_cmd && (io_in == 8'h70);
  assign show_status = (state == S_STATUS) || ((state == S_BUSY) && status_pend);
  assign dout  = show_status ? {1'b1, rb, 6'b000000} : rd_flat[{col, 3'b000} +: 8];
  assign drive = oe_q && ((state == S_READ_OUT) || show_status);
`else
  assign dout  = rd_flat[{col, 3'b000} +: 8];
  assign drive = oe_q && (state == S_READ_OUT);
`endif

  assign F_IO        = drive ? dout : 8'bz;
  assign bus.F_RB    = rb;
  assign bus.cmd_err = err;

  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    return (c == CW'(PAGE_BYTES - 1)) ? '0 : c + 1'b1;
  endfunction

  // One column of storage per generate slice: a program buffer byte plus
  // that column of every page, so commit is a parallel per-column write.
  for (genvar b = 0; b < PAGE_BYTES; b++) begin : g_col
    logic [7:0] pb;
    logic [7:0] cm [NUM_PAGES];
    always_ff @(posedge clk) begin
      if (cyc_data && (state == S_PROG_IN) && (col == CW'(b)))
        pb <= io_in;
      if (commit && mask[b])
        cm[page] <= pb;
    end
    assign rd_flat[b*8 +: 8] = cm[page];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      after_busy <= S_IDLE;
      op_prog    <= 1'b0;
      col        <= '0;
      page       <= '0;
      addr_cnt   <= '0;
      busy_cnt   <= '0;
      rb         <= 1'b1;
      err        <= 1'b0;
      oe_q       <= 1'b0;
      wen_q      <= 1'b1;
      ren_q      <= 1'b1;
      mask       <= '0;
`ifdef NAND_STATUS_EN
      status_pend <= 1'b0;
`endif
    end else begin
      wen_q <= bus.F_WEN;
      ren_q <= bus.F_REN;
      // Drop the drive as soon as a write cycle starts so the controller
      // never fights the target on F_IO.
      oe_q  <= wen_q && bus.F_WEN;
      err   <= cyc_bad;
      if (cmd_rst) begin
        state      <= S_BUSY;
        after_busy <= S_IDLE;
        busy_cnt   <= BW'(T_RST - 1);
        rb         <= 1'b0;
        addr_cnt   <= '0;
        mask       <= '0;
`ifdef NAND_STATUS_EN
        status_pend <= 1'b0;
`endif
      end else begin
        case (state)
          S_ADDR: begin
            if (cyc_cmd) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else if (cyc_addr) begin
              if (addr_cnt == AW'(0)) col  <= CW'(io_in % PAGE_BYTES);
              if (addr_cnt == AW'(1)) page <= PW'(io_in % NUM_PAGES);
              if (addr_cnt == AW'(ADDR_CYCLES - 1)) begin
                addr_cnt <= '0;
                if (op_prog) begin
                  state <= S_PROG_IN;
                end else begin
                  state      <= S_BUSY;
                  after_busy <= S_READ_OUT;
                  busy_cnt   <= BW'(T_R - 1);
                  rb         <= 1'b0;
                end
              end else begin
                addr_cnt <= addr_cnt + 1'b1;
              end
            end
          end
          S_PROG_IN: begin
            if (cyc_cmd) begin
              if (io_in == 8'h10) begin
                state      <= S_BUSY;
                after_busy <= S_IDLE;
                busy_cnt   <= BW'(T_PROG - 1);
                rb         <= 1'b0;
              end else begin
                err   <= 1'b1;
                state <= S_IDLE;
              end
            end else if (cyc_data) begin
              mask[col] <= 1'b1;
              col       <= col_inc(col);
            end
          end
          S_BUSY: begin
`ifdef NAND_STATUS_EN
            if (wr_stb && !cmd_status) err <= 1'b1;
            if (cmd_status) status_pend <= 1'b1;
`else
            if (wr_stb) err <= 1'b1;
`endif
            if (busy_cnt == '0) begin
              rb <= 1'b1;
`ifdef NAND_STATUS_EN
              state       <= (status_pend || cmd_status) ? S_STATUS : after_busy;
              status_pend <= 1'b0;
`else
              state <= after_busy;
`endif
            end else begin
              busy_cnt <= busy_cnt - 1'b1;
            end
          end
          default: begin
            // IDLE, READ_OUT and STATUS share command decode.
            if (cyc_cmd) begin
              case (io_in)
                8'h00: begin
                  state    <= S_ADDR;
                  op_prog  <= 1'b0;
                  addr_cnt <= '0;
                end
                8'h80: begin
                  state    <= S_ADDR;
                  op_prog  <= 1'b1;
                  addr_cnt <= '0;
                  mask     <= '0;
                end
`ifdef NAND_STATUS_EN
                8'h70:   state <= S_STATUS;
`endif
                default: begin
                  state <= S_IDLE;
                  err   <= 1'b1;
                end
              endcase
            end else if (rd_stb && (state == S_READ_OUT)) begin
              col <= col_inc(col);
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nand_page_target.sv
module tb_nand_page_target;
  localparam int PB = 32;
  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tb_drv = 1'b1;
  logic [7:0] tb_d = 8'h3C;
  wire  [7:0] f_io;

  assign f_io = tb_drv ? tb_d : 8'bz;

  nand_page_target_if bus();
  nand_page_target dut (.clk(clk), .rst(rst), .F_IO(f_io), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  logic [7:0] model [NP][PB];
  bit         known [NP][PB];

  always @(negedge clk) if (bus.cmd_err === 1'b1) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic cle, input logic ale, input logic [7:0] d);
    @(negedge clk);
    tb_drv = 1'b1; tb_d = d; bus.F_CLE = cle; bus.F_ALE = ale; bus.F_WEN = 1'b0;
    @(negedge clk);
    bus.F_WEN = 1'b1;
    @(negedge clk);
    bus.F_CLE = 1'b0; bus.F_ALE = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (bus.F_RB === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic prog(input logic [7:0] row0, input logic [7:0] c, input int len, input bit ramp);
    int pg, cc, n;
    logic [7:0] d;
    pg = int'(row0) % NP;
    cc = int'(c) % PB;
    send(1, 0, 8'h80); send(0, 1, c); send(0, 1, row0); send(0, 1, 8'($urandom));
    for (int i = 0; i < len; i++) begin
      d = ramp ? 8'(i) : 8'($urandom);
      send(0, 0, d);
      model[pg][(cc + i) % PB] = d;
      known[pg][(cc + i) % PB] = 1'b1;
    end
    send(1, 0, 8'h10);
    busy_len(n);
    chk("t_prog", n, 16);
  endtask

  task automatic rd(input logic [7:0] row0, input logic [7:0] c, input int len, input string tag);
    int pg, cc, n, idx;
    pg = int'(row0) % NP;
    cc = int'(c) % PB;
    send(1, 0, 8'h00); send(0, 1, c); send(0, 1, row0); send(0, 1, 8'($urandom));
    tb_drv = 1'b0;
    busy_len(n);
    chk({tag, "_tr"}, n, 8);
    for (int i = 0; i < len; i++) begin
      idx = (cc + i) % PB;
      if (known[pg][idx]) chk(tag, {24'b0, f_io}, {24'b0, model[pg][idx]});
      bus.F_REN = 1'b0;
      @(negedge clk);
      bus.F_REN = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, e0;
    logic [7:0] r0;
    bus.F_CLE = 1'b0; bus.F_ALE = 1'b0; bus.F_WEN = 1'b1; bus.F_REN = 1'b1;
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < PB; b++) begin
        known[p][b] = 1'b0;
        model[p][b] = 8'h00;
      end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rb", {31'b0, bus.F_RB}, 1);
    chk("rst_err", {31'b0, bus.cmd_err}, 0);
    chk("rst_bus", {24'b0, f_io}, 32'h3C);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset command busy window
    e0 = err_cnt;
    send(1, 0, 8'hFF);
    busy_len(n);
    chk("t_rst", n, 4);
    #1 chk("ff_no_err", err_cnt - e0, 0);

    // Full page program then read back
    prog(8'h01, 8'h00, 32, 1'b1);
    rd(8'h01, 8'h00, 32, "ramp_rd");

    // Column wrap
    rd(8'h01, 8'h1E, 3, "wrap_rd");

    // FF aborts a program, partial data discarded
    send(1, 0, 8'h80); send(0, 1, 8'h00); send(0, 1, 8'h01); send(0, 1, 8'h00);
    for (int i = 0; i < 10; i++) send(0, 0, 8'(8'hA0 + i));
    send(1, 0, 8'hFF);
    busy_len(n);
    chk("abort_t_rst", n, 4);
    rd(8'h01, 8'h00, 32, "abort_rd");

    // Unknown command in IDLE (bus held at 55 by the bench only)
    e0 = err_cnt;
    send(1, 0, 8'h55);
    repeat (3) @(negedge clk);
    #1;
    chk("c55_err", err_cnt - e0, 1);
    chk("c55_rb", {31'b0, bus.F_RB}, 1);
    chk("c55_bus", {24'b0, f_io}, 32'h55);

    // CLE and ALE both high
    e0 = err_cnt;
    send(1, 1, 8'h00);
    repeat (2) @(negedge clk);
    #1 chk("both_hi_err", err_cnt - e0, 1);

    // Non-FF command during address phase
    e0 = err_cnt;
    send(1, 0, 8'h80); send(0, 1, 8'h04);
    send(1, 0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    chk("addr_cmd_err", err_cnt - e0, 1);
    chk("addr_cmd_rb", {31'b0, bus.F_RB}, 1);

    // Randomized program/read pairs against the page model
    for (int it = 0; it < 6; it++) begin
      r0 = 8'($urandom);
      prog(r0, 8'($urandom), 1 + int'($urandom_range(39, 0)), 1'b0);
      rd(r0 ^ (8'($urandom) & 8'hFC), 8'($urandom), 1 + int'($urandom_range(39, 0)), "rand_rd");
    end

    // Reset mid-busy: state clears, committed memory persists
    send(1, 0, 8'h80); send(0, 1, 8'h05); send(0, 1, 8'h03); send(0, 1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      r0 = 8'($urandom);
      send(0, 0, r0);
      model[3][5 + i] = r0;
      known[3][5 + i] = 1'b1;
    end
    send(1, 0, 8'h10);
    @(negedge clk);
    chk("pre_rst_busy", {31'b0, bus.F_RB}, 0);
    rst = 1'b0;
    #1 chk("mid_rst_rb", {31'b0, bus.F_RB}, 1);
    @(negedge clk);
    rst = 1'b1;
    rd(8'h03, 8'h05, 5, "persist_rd");

`ifdef NAND_STATUS_EN
    // Status during and after program busy
    e0 = err_cnt;
    send(1, 0, 8'h80); send(0, 1, 8'h00); send(0, 1, 8'h02); send(0, 1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      r0 = 8'($urandom);
      send(0, 0, r0);
      model[2][i] = r0;
      known[2][i] = 1'b1;
    end
    send(1, 0, 8'h10);
    send(1, 0, 8'h70);
    tb_drv = 1'b0;
    @(negedge clk);
    chk("status_busy", {24'b0, f_io}, 32'h80);
    busy_len(n);
    @(negedge clk);
    chk("status_ready", {24'b0, f_io}, 32'hC0);
    #1 chk("status_no_err", err_cnt - e0, 0);
    rd(8'h02, 8'h00, 4, "post_status_rd");
`else
    e0 = err_cnt;
    send(1, 0, 8'h70);
    repeat (2) @(negedge clk);
    #1;
    chk("c70_err", err_cnt - e0, 1);
    chk("c70_rb", {31'b0, bus.F_RB}, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
